seg_scan_pages: RTL and testbench

Parametrised multiplexed seven-segment scan driver for board top levels. It shows DIGITS hex digits per page from PAGES pages of packed nibbles, such as instr/pc/memory address/data words. A raw push-button, debounced internally, steps through the pages. Features:
- 16-level brightness PWM
- optional leading-zero blanking
- a hold mode that freezes a snapshot of all pages while the core keeps running

---
 rtl/seg_pkg.sv | 19 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/seg_scan_pages.sv | 119 +++++++++++
 tb/tb_seg_scan_pages.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// blanked-segment value and the digit grouping used for leading-zero blanking.
package seg_pkg;

    localparam int DIGITS_PER_WORD = 8;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Segment patterns in gfedcba order, indexed by nibble value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, consecutive-sample debounce
// counter and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync_q, sync_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles the synchronised level disagrees with the accepted level;
    // any agreeing sample restarts the count.
    always_comb begin
        sync_d   = {sync_q[0], btn_in};
        stable_d = stable_q;
        rise_d   = 1'b0;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                stable_d = sync_q[1];
                rise_d   = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/seg_scan_pages.sv
// Multiplexed seven-segment scan driver with paged data, PWM brightness,
// optional leading-zero blanking and a hold snapshot of all pages.
module seg_scan_pages
    import seg_pkg::*;
#(
    parameter int DIGITS       = 16,
    parameter int PAGES        = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LZ_BLANK     = 0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [PAGES*DIGITS*4-1:0]                   data,
    input  logic [DIGITS-1:0]                           dp,
    input  logic                                        page_btn,
    input  logic                                        hold,
    input  logic [3:0]                                  brightness,
    output logic [((PAGES > 1) ? $clog2(PAGES) : 1)-1:0] page,
    output logic [DIGITS-1:0]                           seg_sel_n,
    output logic [7:0]                                  seg
);

    localparam int PW   = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW   = $clog2(SCAN_DIV);
    localparam int STEP = SCAN_DIV / 16;
    localparam int WW   = DIGITS * 4;

    logic [SW-1:0]         slot_q, slot_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [PW-1:0]         page_q, page_d;
    logic [2:0]            hold_sync_q, hold_sync_d;
    logic [PAGES*WW-1:0]   snap_q, snap_d;
    logic [DIGITS-1:0]     seg_sel_n_q, seg_sel_n_d;
    logic [7:0]            seg_q, seg_d;
    logic                  btn_rise;

    logic [PAGES*WW-1:0]   src;
    logic [WW-1:0]         word;
    logic [3:0]            nib;
    logic                  lit;
    logic                  nonzero_above;
    logic                  blank;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_page_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (page_btn),
        .rise   (btn_rise)
    );

    always_comb begin
        slot_d  = slot_q + SW'(1);
        digit_d = digit_q;
        if (slot_q == SW'(SCAN_DIV - 1)) begin
            slot_d  = '0;
            digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + DW'(1);
        end

        page_d = page_q;
        if (btn_rise) begin
            page_d = (int'(page_q) == PAGES - 1) ? '0 : page_q + PW'(1);
        end

        // Stage 2 of the hold pipeline rising loads the snapshot; stage 3
        // switches the display source in the same cycle the load lands.
        hold_sync_d = {hold_sync_q[1:0], hold};
        snap_d      = (hold_sync_q[1] && !hold_sync_q[2]) ? data : snap_q;

        src  = hold_sync_q[2] ? snap_q : data;
        word = src[int'(page_q)*WW +: WW];
        nib  = word[int'(digit_q)*4 +: 4];
        lit  = 32'(slot_q) < (32'(brightness) + 32'd1) * 32'(STEP);

        nonzero_above = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i / DIGITS_PER_WORD) == (int'(digit_q) / DIGITS_PER_WORD) &&
                i >= int'(digit_q) && word[i*4 +: 4] != 4'h0) begin
                nonzero_above = 1'b1;
            end
        end
        blank = (LZ_BLANK != 0) && ((int'(digit_q) % DIGITS_PER_WORD) != 0) && !nonzero_above;

        seg_sel_n_d = '1;
        seg_d       = SEG_OFF;
        if (lit) begin
            seg_sel_n_d = ~(DIGITS'(1) << digit_q);
            if (!blank) begin
                seg_d = {dp[digit_q], hex_to_seg(nib)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            digit_q     <= '0;
            page_q      <= '0;
            hold_sync_q <= '0;
            snap_q      <= '0;
            seg_sel_n_q <= '1;
            seg_q       <= SEG_OFF;
        end else begin
            slot_q      <= slot_d;
            digit_q     <= digit_d;
            page_q      <= page_d;
            hold_sync_q <= hold_sync_d;
            snap_q      <= snap_d;
            seg_sel_n_q <= seg_sel_n_d;
            seg_q       <= seg_d;
        end
    end

    assign page      = page_q;
    assign seg_sel_n = seg_sel_n_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_seg_scan_pages.sv
// Self-checking bench: two instances (plain and leading-zero blanking) driven
// together and compared every cycle against a cycle-count based model.
module tb_seg_scan_pages;

    localparam int DIGITS       = 8;
    localparam int PAGES        = 2;
    localparam int SCAN_DIV     = 16;
    localparam int DEBOUNCE_CYC = 8;
    localparam int WW           = DIGITS * 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [PAGES*WW-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic                  page_btn;
    logic                  hold;
    logic [3:0]            brightness;
    logic                  page0, page1;
    logic [DIGITS-1:0]     sel0, sel1;
    logic [7:0]            seg0, seg1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_pages #(
        .DIGITS(DIGITS), .PAGES(PAGES), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .LZ_BLANK(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .page_btn(page_btn),
        .hold(hold), .brightness(brightness), .page(page0),
        .seg_sel_n(sel0), .seg(seg0)
    );

    seg_scan_pages #(
        .DIGITS(DIGITS), .PAGES(PAGES), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .LZ_BLANK(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .page_btn(page_btn),
        .hold(hold), .brightness(brightness), .page(page1),
        .seg_sel_n(sel1), .seg(seg1)
    );

    // ---------------- reference model ----------------
    int                  m_edges;
    int                  m_page;
    bit                  m_stable;
    bit                  m_pending;
    bit                  m_lvl[$];
    bit                  m_btn_hist[2];
    bit                  m_hold_hist[3];
    logic [PAGES*WW-1:0] m_snap;
    logic [DIGITS-1:0]   exp_sel;
    logic [7:0]          exp_seg0, exp_seg1;
    bit                  cmp_en = 1'b0;

    function automatic logic [6:0] hexSeg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] segFor(input logic [WW-1:0] w, input int d,
                                          input logic dpb, input bit lz);
        bit all_zero = 1'b1;
        int top = (d / 8) * 8 + 7;
        for (int i = d; i <= top; i++) begin
            if (w[i*4 +: 4] != 4'h0) all_zero = 1'b0;
        end
        if (lz && (d % 8) != 0 && all_zero) return 8'h00;
        return {dpb, hexSeg(w[d*4 +: 4])};
    endfunction

    task automatic resetModel();
        m_edges        = 0;
        m_page         = 0;
        m_stable       = 1'b0;
        m_pending      = 1'b0;
        m_lvl.delete();
        m_btn_hist     = '{default: 1'b0};
        m_hold_hist    = '{default: 1'b0};
        m_snap         = '0;
        exp_sel        = '1;
        exp_seg0       = 8'h00;
        exp_seg1       = 8'h00;
    endtask

    // Outputs after the n-th edge describe slot (n-1)%SCAN_DIV of digit
    // ((n-1)/SCAN_DIV)%DIGITS, using inputs present at that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resetModel();
        end else begin
            int slot, dig;
            bit lit, all_diff;
            logic [PAGES*WW-1:0] src;
            logic [WW-1:0] word;
            m_edges++;
            slot = (m_edges - 1) % SCAN_DIV;
            dig  = ((m_edges - 1) / SCAN_DIV) % DIGITS;
            src  = m_hold_hist[2] ? m_snap : data;
            word = src[m_page*WW +: WW];
            lit  = slot < (int'(brightness) + 1) * (SCAN_DIV / 16);
            exp_sel  = lit ? ~(DIGITS'(1) << dig) : '1;
            exp_seg0 = lit ? segFor(word, dig, dp[dig], 1'b0) : 8'h00;
            exp_seg1 = lit ? segFor(word, dig, dp[dig], 1'b1) : 8'h00;

            if (m_hold_hist[1] && !m_hold_hist[2]) m_snap = data;
            m_hold_hist[2] = m_hold_hist[1];
            m_hold_hist[1] = m_hold_hist[0];
            m_hold_hist[0] = hold;

            // Button level accepted once the last DEBOUNCE_CYC synchronised
            // samples all disagree with the current accepted level.
            if (m_pending) m_page = (m_page + 1) % PAGES;
            m_pending = 1'b0;
            m_lvl.push_back(m_btn_hist[1]);
            if (m_lvl.size() > DEBOUNCE_CYC) void'(m_lvl.pop_front());
            all_diff = (m_lvl.size() == DEBOUNCE_CYC);
            foreach (m_lvl[k]) if (m_lvl[k] == m_stable) all_diff = 1'b0;
            if (all_diff) begin
                m_stable  = ~m_stable;
                m_pending = m_stable;
            end
            m_btn_hist[1] = m_btn_hist[0];
            m_btn_hist[0] = page_btn;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("sel0", 32'(sel0), 32'(exp_sel));
            checkOutput("seg0", 32'(seg0), 32'(exp_seg0));
            checkOutput("sel1", 32'(sel1), 32'(exp_sel));
            checkOutput("seg1", 32'(seg1), 32'(exp_seg1));
            checkOutput("page0", 32'(page0), 32'(m_page));
            checkOutput("page1", 32'(page1), 32'(m_page));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic press(input int len);
        page_btn = 1'b1;
        tick(len);
        page_btn = 1'b0;
        tick(12);
    endtask

    task automatic waitDigit(input int d);
        bit found = 1'b0;
        tick(1);
        for (int i = 0; i < 300 && !found; i++) begin
            if (sel1 == ~(DIGITS'(1) << d)) found = 1'b1;
            else tick(1);
        end
        if (!found) checkOutput("digit_timeout", 32'(sel1), 32'(~(DIGITS'(1) << d)));
    endtask

    task automatic applyStimulus(input int i);
        int bp = ((i / 200) % 2 == 1) ? 20 : 4;
        if ($urandom_range(0, 31) == 0)
            data = {$urandom >> $urandom_range(0, 31), $urandom >> $urandom_range(0, 31)};
        if ($urandom_range(0, 15) == 0) dp = DIGITS'($urandom);
        if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
        if ($urandom_range(0, 99) == 0) hold = ~hold;
        if ($urandom_range(1, bp) == 1) page_btn = ~page_btn;
        tick(1);
    endtask

    initial begin
        int cnt;
        logic [7:0] lz_a [8];
        logic [7:0] lz_b [8];
        lz_a = '{8'h6D, 8'h3F, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        lz_b = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        rst_n = 1'b0; dp = '0; page_btn = 1'b0; hold = 1'b0; brightness = 4'd15;
        data = {32'h44444444, 32'h0123ABCF};
        resetModel();
        tick(3);
        checkOutput("reset_sel", 32'(sel0), 32'h000000FF);
        checkOutput("reset_seg", 32'(seg0), 32'h00000000);
        checkOutput("reset_page", 32'(page0), 32'h0);
        cmp_en = 1'b1;

        $display("[TB] scan order");
        rst_n = 1'b1;
        tick(1);
        checkOutput("scan_d0_sel", 32'(sel0), 32'h000000FE);
        checkOutput("scan_d0_seg", 32'(seg0), 32'h00000071);
        tick(16);
        checkOutput("scan_d1_sel", 32'(sel0), 32'h000000FD);
        checkOutput("scan_d1_seg", 32'(seg0), 32'h00000039);
        tick(96);
        checkOutput("scan_d7_sel", 32'(sel0), 32'h0000007F);
        checkOutput("scan_d7_seg", 32'(seg0), 32'h0000003F);
        checkOutput("scan_d7_lz", 32'(seg1), 32'h00000000);
        tick(16);
        checkOutput("scan_wrap_sel", 32'(sel0), 32'h000000FE);

        $display("[TB] debounce");
        for (int len = 1; len < DEBOUNCE_CYC; len++) begin
            page_btn = 1'b1; tick(len); page_btn = 1'b0; tick(10);
        end
        checkOutput("bounce_page", 32'(page0), 32'h0);
        press(12);
        checkOutput("press_page", 32'(page0), 32'h1);
        checkOutput("page1_data", 32'(seg0), 32'h00000066);
        press(12);
        checkOutput("wrap_page", 32'(page0), 32'h0);

        $display("[TB] brightness");
        brightness = 4'd3;
        tick(20);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (sel0 != '1) cnt++;
            tick(1);
        end
        checkOutput("duty_4_of_16", 32'(cnt), 32'd8);
        brightness = 4'd15;
        tick(20);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (sel0 != '1) cnt++;
            tick(1);
        end
        checkOutput("duty_full", 32'(cnt), 32'd32);

        $display("[TB] hold");
        data = {32'h11111111, 32'h11111111};
        tick(2);
        hold = 1'b1;
        tick(5);
        data = {32'h22222222, 32'h22222222};
        tick(40);
        checkOutput("hold_frozen", 32'(seg0), 32'h00000006);
        hold = 1'b0;
        tick(4);
        checkOutput("hold_release", 32'(seg0), 32'h0000005B);

        $display("[TB] leading-zero blanking");
        data = {32'h00000A05, 32'h00000A05};
        tick(2);
        for (int d = 0; d < 8; d++) begin
            waitDigit(d);
            checkOutput($sformatf("lz_a_d%0d", d), 32'(seg1), 32'(lz_a[d]));
        end
        data = '0;
        tick(2);
        for (int d = 0; d < 8; d++) begin
            waitDigit(d);
            checkOutput($sformatf("lz_b_d%0d", d), 32'(seg1), 32'(lz_b[d]));
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) applyStimulus(i);

        $display("[TB] reset mid-operation");
        hold = 1'b0; page_btn = 1'b0;
        tick(20);
        if (m_page != 1) press(12);
        checkOutput("pre_reset_page", 32'(page0), 32'h1);
        tick(5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_page", 32'(page0), 32'h0);
        checkOutput("async_sel", 32'(sel0), 32'h000000FF);
        checkOutput("async_seg", 32'(seg0), 32'h00000000);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checkOutput("restart_sel", 32'(sel0), 32'h000000FE);
        tick(50);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
